// File: rtl/regs_wport_arb_if.sv
// Bundle of the ex/LU inputs and regs-facing outputs of the write-port arbiter.
// master drives ex and LU results; slave is the arbiter.
interface regs_wport_arb_if;
    logic [4:0]  ex_rd_addr_i;
    logic [31:0] ex_rd_data_i;
    logic        ex_rd_wen_i;
    logic        lu_valid_i;
    logic [4:0]  lu_rd_addr_i;
    logic [31:0] lu_rd_data_i;
    logic        lu_ready_o;
    logic [4:0]  rd_addr_o;
    logic [31:0] rd_data_o;
    logic        rd_wen_o;
    logic        hold_o;
    logic        err_o;

    modport master (
        output ex_rd_addr_i, ex_rd_data_i, ex_rd_wen_i,
        output lu_valid_i, lu_rd_addr_i, lu_rd_data_i,
        input  lu_ready_o, rd_addr_o, rd_data_o, rd_wen_o, hold_o, err_o
    );

    modport slave (
        input  ex_rd_addr_i, ex_rd_data_i, ex_rd_wen_i,
        input  lu_valid_i, lu_rd_addr_i, lu_rd_data_i,
        output lu_ready_o, rd_addr_o, rd_data_o, rd_wen_o, hold_o, err_o
    );
endinterface

// File: rtl/regs_wport_arb.sv
// Arbitrates the register-file write port between ex and a long-latency unit via a small LU FIFO.
// Latency: 1 cycle from grant to rd_*_o; LU results may wait in the FIFO until ex leaves the port idle.
// Backpressure: ex has none (hold_o requests a bubble); LU sees lu_ready_o = FIFO not full.
module regs_wport_arb #(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    regs_wport_arb_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [4:0]       fifo_addr_q [DEPTH];
    logic [31:0]      fifo_data_q [DEPTH];
    logic [DEPTH-1:0] fifo_vld_q, fifo_vld_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [SW-1:0]    starve_q, starve_d;
    logic             hold_q, hold_d;
    logic             err_q, err_d;
    logic [4:0]       rd_addr_q, rd_addr_d;
    logic [31:0]      rd_data_q, rd_data_d;
    logic             rd_wen_q, rd_wen_d;

    logic ex_eff, fifo_empty, lu_ready, lu_acc, lu_drop;
    logic pop, push, bypass;

    always_comb begin
        ex_eff     = bus.ex_rd_wen_i && (bus.ex_rd_addr_i != 5'd0);
        fifo_empty = (count_q == '0);
        lu_ready   = (count_q != CW'(DEPTH));
        lu_acc     = bus.lu_valid_i && lu_ready;
        // A same-cycle LU result to the register ex is writing is older, so it dies here.
        lu_drop    = (bus.lu_rd_addr_i == 5'd0)
                   || (ex_eff && (bus.lu_rd_addr_i == bus.ex_rd_addr_i));
        // ex wins even during hold; otherwise a non-empty FIFO always owns the port.
        pop        = !ex_eff && !fifo_empty;
        bypass     = !ex_eff && fifo_empty && lu_acc && !lu_drop;
        push       = lu_acc && !lu_drop && !bypass;
    end

    always_comb begin
        rd_wen_d  = 1'b0;
        rd_addr_d = rd_addr_q;
        rd_data_d = rd_data_q;
        if (ex_eff) begin
            rd_wen_d  = 1'b1;
            rd_addr_d = bus.ex_rd_addr_i;
            rd_data_d = bus.ex_rd_data_i;
        end else if (pop) begin
            if (fifo_vld_q[rd_ptr_q]) begin
                rd_wen_d  = 1'b1;
                rd_addr_d = fifo_addr_q[rd_ptr_q];
                rd_data_d = fifo_data_q[rd_ptr_q];
            end
        end else if (bypass) begin
            rd_wen_d  = 1'b1;
            rd_addr_d = bus.lu_rd_addr_i;
            rd_data_d = bus.lu_rd_data_i;
        end
    end

    always_comb begin
        fifo_vld_d = fifo_vld_q;
        // Killed entries keep their slot and later drain as dead pops.
        if (ex_eff) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (fifo_addr_q[i] == bus.ex_rd_addr_i) begin
                    fifo_vld_d[i] = 1'b0;
                end
            end
        end
        if (push) begin
            fifo_vld_d[wr_ptr_q] = 1'b1;
        end
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
    end

    always_comb begin
        starve_d = starve_q;
        hold_d   = 1'b0;
        if (fifo_empty || pop) begin
            starve_d = '0;
        end else if (starve_q == SW'(STARVE_MAX - 1)) begin
            starve_d = '0;
            hold_d   = !hold_q;
        end else begin
            starve_d = starve_q + SW'(1);
        end
        err_d = err_q || (hold_q && bus.ex_rd_wen_i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_vld_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            starve_q   <= '0;
            hold_q     <= 1'b0;
            err_q      <= 1'b0;
            rd_addr_q  <= '0;
            rd_data_q  <= '0;
            rd_wen_q   <= 1'b0;
        end else begin
            fifo_vld_q <= fifo_vld_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            starve_q   <= starve_d;
            hold_q     <= hold_d;
            err_q      <= err_d;
            rd_addr_q  <= rd_addr_d;
            rd_data_q  <= rd_data_d;
            rd_wen_q   <= rd_wen_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= bus.lu_rd_addr_i;
            fifo_data_q[wr_ptr_q] <= bus.lu_rd_data_i;
        end
    end

    assign bus.lu_ready_o = lu_ready;
    assign bus.rd_addr_o  = rd_addr_q;
    assign bus.rd_data_o  = rd_data_q;
    assign bus.rd_wen_o   = rd_wen_q;
    assign bus.hold_o     = hold_q;
    assign bus.err_o      = err_q;
endmodule
